// File: rtl/mips_mem_pkg.sv
// Shared definitions for the MEM-stage load/store engine.
//  - l_s_typeM one-hot bit positions and their single-bit patterns
//  - data bus size encodings
//  - access FSM state type
//  - lsSize(): maps a load/store type to a bus size. A type that is not
//    one-hot falls back to a word access.
package mips_mem_pkg;

  // Bit positions inside the one-hot l_s_typeM vector.
  localparam int LS_LB  = 0;
  localparam int LS_LBU = 1;
  localparam int LS_LH  = 2;
  localparam int LS_LHU = 3;
  localparam int LS_LW  = 4;
  localparam int LS_SB  = 5;
  localparam int LS_SH  = 6;
  localparam int LS_SW  = 7;

  // Single-bit type patterns, used as case items.
  localparam logic [7:0] T_LB  = 8'b1 << LS_LB;
  localparam logic [7:0] T_LBU = 8'b1 << LS_LBU;
  localparam logic [7:0] T_LH  = 8'b1 << LS_LH;
  localparam logic [7:0] T_LHU = 8'b1 << LS_LHU;
  localparam logic [7:0] T_LW  = 8'b1 << LS_LW;
  localparam logic [7:0] T_SB  = 8'b1 << LS_SB;
  localparam logic [7:0] T_SH  = 8'b1 << LS_SH;
  localparam logic [7:0] T_SW  = 8'b1 << LS_SW;

  // data_size encodings on the bus.
  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // no transaction outstanding
    S_REQ  = 2'd1,  // request raised, waiting for addr_ok
    S_WAIT = 2'd2,  // address accepted, waiting for data_ok
    S_HOLD = 2'd3   // done, pipeline still held by someone else
  } memState_t;

  function automatic logic [1:0] lsSize(input logic [7:0] lsType);
    logic [1:0] size;
    case (lsType)
      T_LB, T_LBU, T_SB: size = SIZE_BYTE;
      T_LH, T_LHU, T_SH: size = SIZE_HALF;
      default:           size = SIZE_WORD;
    endcase
    return size;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Load data alignment and extension (purely combinational).
// Picks the addressed byte/halfword out of a little-endian 32-bit bus word
// and sign- or zero-extends it according to the load type.
// Ports:
//  rawWord  in  32  word as returned by the data bus
//  byteOff  in   2  address bits [1:0] of the load
//  lsType   in   8  one-hot load/store type
//  result   out 32  aligned, extended load value (LW or unknown type -> rawWord)
module load_extend
  import mips_mem_pkg::*;
(
  input  logic [31:0] rawWord,
  input  logic [1:0]  byteOff,
  input  logic [7:0]  lsType,
  output logic [31:0] result
);

  logic [7:0]  byteSel;
  logic [15:0] halfSel;

  // NOTE: every signal written in an always_comb gets a value on every path
  // (default first or a full case), otherwise synthesis infers a latch.
  always_comb begin
    case (byteOff)
      2'd0:    byteSel = rawWord[7:0];
      2'd1:    byteSel = rawWord[15:8];
      2'd2:    byteSel = rawWord[23:16];
      default: byteSel = rawWord[31:24];
    endcase
    halfSel = byteOff[1] ? rawWord[31:16] : rawWord[15:0];

    case (lsType)
      T_LB:    result = {{24{byteSel[7]}}, byteSel};
      T_LBU:   result = {24'b0, byteSel};
      T_LH:    result = {{16{halfSel[15]}}, halfSel};
      T_LHU:   result = {16'b0, halfSel};
      default: result = rawWord;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine.
// Checks alignment, runs one transaction at a time on an SRAM-like
// req/addr_ok/data_ok data bus, aligns and extends load data, and stalls the
// pipeline until the access completes. A flush while a transaction is in
// flight lets the bus handshake finish and throws the data away.
// Ports:
//  clk, rst          clock; asynchronous active-low reset
//  mem_read_enM      load in MEM
//  mem_write_enM     store in MEM
//  l_s_typeM         one-hot type: LB LBU LH LHU LW SB SH SW (bits 0..7)
//  alu_outM          effective address
//  rt_valueM         store data, low-aligned
//  except_pendM      instruction already faulted elsewhere: no access
//  flushM            MEM flush
//  stall_extM        pipeline held by another source
//  data_req/wr/size/addr/wdata   bus request side
//  data_addr_ok/data_ok/rdata    bus response side
//  mem_rdataM        aligned, extended load result
//  mem_stallM        stall request to the hazard unit
//  adelM / adesM     load / store address error
//  bad_addrM         faulting address, 0 when no address error
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int LS_TYPE_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_read_enM,
  input  logic                 mem_write_enM,
  input  logic [LS_TYPE_W-1:0] l_s_typeM,
  input  logic [ADDR_W-1:0]    alu_outM,
  input  logic [DATA_W-1:0]    rt_valueM,
  input  logic                 except_pendM,
  input  logic                 flushM,
  input  logic                 stall_extM,
  output logic                 data_req,
  output logic                 data_wr,
  output logic [1:0]           data_size,
  output logic [ADDR_W-1:0]    data_addr,
  output logic [DATA_W-1:0]    data_wdata,
  input  logic                 data_addr_ok,
  input  logic                 data_data_ok,
  input  logic [DATA_W-1:0]    data_rdata,
  output logic [DATA_W-1:0]    mem_rdataM,
  output logic                 mem_stallM,
  output logic                 adelM,
  output logic                 adesM,
  output logic [ADDR_W-1:0]    bad_addrM
);

  memState_t stateQ, stateD;
  logic      discardQ, discardD;

  // Transaction fields captured when the request is first raised.
  logic [ADDR_W-1:0]    addrQ;
  logic [1:0]           sizeQ;
  logic                 wrQ;
  logic [LS_TYPE_W-1:0] typeQ;
  logic [DATA_W-1:0]    wdataQ;
  logic [DATA_W-1:0]    bufQ;     // raw read word kept for HOLD

  logic [1:0]        sizeNow;
  logic              misaligned;
  logic              access;
  logic              issue;
  logic              dropping;
  logic              dataDone;
  logic              resultValid;
  logic [DATA_W-1:0] wdataNow;
  logic [DATA_W-1:0] extendIn;
  logic [DATA_W-1:0] extendOut;

  // ---------------------------------------------------------------------
  // Decode of the instruction currently in MEM
  // ---------------------------------------------------------------------
  assign sizeNow = lsSize(l_s_typeM);

  always_comb begin
    misaligned = 1'b0;
    case (sizeNow)
      SIZE_HALF: misaligned = alu_outM[0];
      SIZE_WORD: misaligned = |alu_outM[1:0];
      default:   misaligned = 1'b0;
    endcase
  end

  assign adelM     = mem_read_enM  & misaligned;
  assign adesM     = mem_write_enM & misaligned;
  assign bad_addrM = (adelM | adesM) ? alu_outM : '0;

  assign access = (mem_read_enM | mem_write_enM) & ~adelM & ~adesM
                & ~except_pendM & ~flushM;

  // Store data is replicated across lanes so the bus picks the right bytes
  // from the address alone.
  always_comb begin
    case (sizeNow)
      SIZE_BYTE: wdataNow = {4{rt_valueM[7:0]}};
      SIZE_HALF: wdataNow = {2{rt_valueM[15:0]}};
      default:   wdataNow = rt_valueM;
    endcase
  end

  // ---------------------------------------------------------------------
  // Handshake control
  // ---------------------------------------------------------------------
  // A flush during REQ/WAIT marks the outstanding op as discarded from the
  // flush cycle onwards; discardQ only carries that into later cycles.
  assign dropping = discardQ
                  | (flushM & ((stateQ == S_REQ) | (stateQ == S_WAIT)));

  // New requests only start from IDLE, never while a discarded op drains.
  // Gated by rst so the bus stays quiet while reset is held.
  assign issue = rst & (stateQ == S_IDLE) & access & ~discardQ;

  // data_ok is only meaningful in WAIT; in the addr_ok cycle it is ignored.
  assign dataDone = (stateQ == S_WAIT) & data_data_ok;

  always_comb begin
    stateD   = stateQ;
    discardD = discardQ;
    case (stateQ)
      S_IDLE: begin
        if (issue) stateD = data_addr_ok ? S_WAIT : S_REQ;
      end
      S_REQ: begin
        if (data_addr_ok) stateD = S_WAIT;
      end
      S_WAIT: begin
        if (data_data_ok) stateD = (dropping | ~stall_extM) ? S_IDLE : S_HOLD;
      end
      S_HOLD: begin
        // Flush wins over an external stall; the op is never reissued.
        if (flushM | ~stall_extM) stateD = S_IDLE;
      end
      default: stateD = S_IDLE;
    endcase

    if (flushM & ((stateQ == S_REQ) | (stateQ == S_WAIT))) discardD = 1'b1;
    if (dataDone) discardD = 1'b0;
  end

  always_comb begin
    mem_stallM = 1'b0;
    if (!rst) begin
      mem_stallM = 1'b0;
    end else if (dropping) begin
      // The discarded op itself never stalls; a new access waits for it.
      mem_stallM = access;
    end else begin
      case (stateQ)
        S_IDLE:  mem_stallM = access;
        S_REQ:   mem_stallM = 1'b1;
        S_WAIT:  mem_stallM = ~data_data_ok;
        default: mem_stallM = 1'b0;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Bus outputs: live decode in IDLE, latched fields while pending
  // ---------------------------------------------------------------------
  assign data_req   = issue | (stateQ == S_REQ);
  assign data_addr  = (stateQ == S_IDLE) ? alu_outM      : addrQ;
  assign data_size  = (stateQ == S_IDLE) ? sizeNow       : sizeQ;
  assign data_wr    = (stateQ == S_IDLE) ? mem_write_enM : wrQ;
  assign data_wdata = (stateQ == S_IDLE) ? wdataNow      : wdataQ;

  // ---------------------------------------------------------------------
  // Load result: bypassed from the bus in the data_ok cycle, from the
  // buffer while holding. Stores and dropped ops return 0.
  // ---------------------------------------------------------------------
  assign extendIn    = (stateQ == S_HOLD) ? bufQ : data_rdata;
  assign resultValid = ~wrQ & ((dataDone & ~dropping) | (stateQ == S_HOLD));

  load_extend u_load_extend (
    .rawWord (extendIn),
    .byteOff (addrQ[1:0]),
    .lsType  (typeQ),
    .result  (extendOut)
  );

  assign mem_rdataM = resultValid ? extendOut : '0;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ   <= S_IDLE;
      discardQ <= 1'b0;
      addrQ    <= '0;
      sizeQ    <= SIZE_BYTE;
      wrQ      <= 1'b0;
      typeQ    <= '0;
      wdataQ   <= '0;
      bufQ     <= '0;
    end else begin
      stateQ   <= stateD;
      discardQ <= discardD;
      if (issue) begin
        addrQ  <= alu_outM;
        sizeQ  <= sizeNow;
        wrQ    <= mem_write_enM;
        typeQ  <= l_s_typeM;
        wdataQ <= wdataNow;
      end
      if (dataDone & ~dropping) bufQ <= data_rdata;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam logic [7:0] tLB  = 8'h01;
  localparam logic [7:0] tLBU = 8'h02;
  localparam logic [7:0] tLH  = 8'h04;
  localparam logic [7:0] tLHU = 8'h08;
  localparam logic [7:0] tLW  = 8'h10;
  localparam logic [7:0] tSB  = 8'h20;
  localparam logic [7:0] tSH  = 8'h40;
  localparam logic [7:0] tSW  = 8'h80;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_enM, mem_write_enM;
  logic [7:0]  l_s_typeM;
  logic [31:0] alu_outM, rt_valueM;
  logic        except_pendM, flushM, stall_extM;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic [31:0] mem_rdataM;
  logic        mem_stallM, adelM, adesM;
  logic [31:0] bad_addrM;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk           (clk),
    .rst           (rst),
    .mem_read_enM  (mem_read_enM),
    .mem_write_enM (mem_write_enM),
    .l_s_typeM     (l_s_typeM),
    .alu_outM      (alu_outM),
    .rt_valueM     (rt_valueM),
    .except_pendM  (except_pendM),
    .flushM        (flushM),
    .stall_extM    (stall_extM),
    .data_req      (data_req),
    .data_wr       (data_wr),
    .data_size     (data_size),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .data_addr_ok  (data_addr_ok),
    .data_data_ok  (data_data_ok),
    .data_rdata    (data_rdata),
    .mem_rdataM    (mem_rdataM),
    .mem_stallM    (mem_stallM),
    .adelM         (adelM),
    .adesM         (adesM),
    .bad_addrM     (bad_addrM)
  );

  typedef struct {
    string       name;
    logic        rd;
    logic        wr;
    logic [7:0]  lsType;
    logic [31:0] addr;
    logic [31:0] rt;
    logic        exc;
    logic        flush;
    logic        eReq;
    logic        eWr;
    logic [1:0]  eSize;
    logic [31:0] eWdata;
    logic        eAdel;
    logic        eAdes;
    logic [31:0] eBad;
    logic        eStall;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else passed++;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    mem_read_enM  = 1'b0;
    mem_write_enM = 1'b0;
    l_s_typeM     = 8'h00;
    alu_outM      = 32'h0;
    rt_valueM     = 32'h0;
    except_pendM  = 1'b0;
    flushM        = 1'b0;
    stall_extM    = 1'b0;
    data_addr_ok  = 1'b0;
    data_data_ok  = 1'b0;
    data_rdata    = 32'h0;
  endtask

  // Load with addr_ok in the request cycle and data_ok one cycle later.
  task automatic doLoad(input string name, input logic [7:0] t, input logic [31:0] a,
                        input logic [31:0] raw, input logic [31:0] exp);
    mem_read_enM = 1'b1; l_s_typeM = t; alu_outM = a; data_addr_ok = 1'b1;
    #1;
    check({name, "_req"}, {31'b0, data_req}, 32'd1);
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = raw;
    #1;
    check({name, "_data"}, mem_rdataM, exp);
    check({name, "_nostall"}, {31'b0, mem_stallM}, 32'd0);
    step();
    idleInputs();
  endtask

  initial begin
    vecs[0]  = '{"lw_ok",     1'b1, 1'b0, tLW,   32'h8000_1004, 32'h0,         1'b0, 1'b0,
                 1'b1, 1'b0, 2'd2, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1};
    vecs[1]  = '{"sh_ok",     1'b0, 1'b1, tSH,   32'h1000_0002, 32'h1234_ABCD, 1'b0, 1'b0,
                 1'b1, 1'b1, 2'd1, 32'hABCD_ABCD, 1'b0, 1'b0, 32'h0,         1'b1};
    vecs[2]  = '{"sw_mis",    1'b0, 1'b1, tSW,   32'h1000_0001, 32'h1234_ABCD, 1'b0, 1'b0,
                 1'b0, 1'b1, 2'd2, 32'h0,         1'b0, 1'b1, 32'h1000_0001, 1'b0};
    vecs[3]  = '{"sb_ok",     1'b0, 1'b1, tSB,   32'h1000_0003, 32'h1234_ABCD, 1'b0, 1'b0,
                 1'b1, 1'b1, 2'd0, 32'hCDCD_CDCD, 1'b0, 1'b0, 32'h0,         1'b1};
    vecs[4]  = '{"lh_mis",    1'b1, 1'b0, tLH,   32'h2000_0001, 32'h0,         1'b0, 1'b0,
                 1'b0, 1'b0, 2'd1, 32'h0,         1'b1, 1'b0, 32'h2000_0001, 1'b0};
    vecs[5]  = '{"lw_mis",    1'b1, 1'b0, tLW,   32'h2000_0002, 32'h0,         1'b0, 1'b0,
                 1'b0, 1'b0, 2'd2, 32'h0,         1'b1, 1'b0, 32'h2000_0002, 1'b0};
    vecs[6]  = '{"lhu_ok",    1'b1, 1'b0, tLHU,  32'h2000_0002, 32'h0,         1'b0, 1'b0,
                 1'b1, 1'b0, 2'd1, 32'h0,         1'b0, 1'b0, 32'h0,         1'b1};
    vecs[7]  = '{"lw_exc",    1'b1, 1'b0, tLW,   32'h3000_0000, 32'h0,         1'b1, 1'b0,
                 1'b0, 1'b0, 2'd2, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0};
    vecs[8]  = '{"lw_flush",  1'b1, 1'b0, tLW,   32'h3000_0000, 32'h0,         1'b0, 1'b1,
                 1'b0, 1'b0, 2'd2, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0};
    vecs[9]  = '{"none",      1'b0, 1'b0, tLW,   32'h3000_0001, 32'h0,         1'b0, 1'b0,
                 1'b0, 1'b0, 2'd2, 32'h0,         1'b0, 1'b0, 32'h0,         1'b0};
    vecs[10] = '{"st_multi",  1'b0, 1'b1, 8'h60, 32'h4000_0004, 32'h1122_3344, 1'b0, 1'b0,
                 1'b1, 1'b1, 2'd2, 32'h1122_3344, 1'b0, 1'b0, 32'h0,         1'b1};
    vecs[11] = '{"ld_multi",  1'b1, 1'b0, 8'h03, 32'h4000_0002, 32'h0,         1'b0, 1'b0,
                 1'b0, 1'b0, 2'd2, 32'h0,         1'b1, 1'b0, 32'h4000_0002, 1'b0};

    idleInputs();
    rst = 1'b0;

    // Reset held with a valid load on the inputs: bus and stall stay quiet.
    mem_read_enM = 1'b1; l_s_typeM = tLW; alu_outM = 32'h8000_1004;
    step();
    check("rst_req", {31'b0, data_req}, 32'd0);
    check("rst_stall", {31'b0, mem_stallM}, 32'd0);
    check("rst_rdata", mem_rdataM, 32'd0);
    idleInputs();
    step();
    rst = 1'b1;
    step();

    // Single-cycle decode in IDLE; inputs are cleared before the next edge.
    for (int i = 0; i < 12; i++) begin
      step();
      mem_read_enM  = vecs[i].rd;
      mem_write_enM = vecs[i].wr;
      l_s_typeM     = vecs[i].lsType;
      alu_outM      = vecs[i].addr;
      rt_valueM     = vecs[i].rt;
      except_pendM  = vecs[i].exc;
      flushM        = vecs[i].flush;
      #1;
      check({vecs[i].name, "_req"},   {31'b0, data_req},   {31'b0, vecs[i].eReq});
      check({vecs[i].name, "_adel"},  {31'b0, adelM},      {31'b0, vecs[i].eAdel});
      check({vecs[i].name, "_ades"},  {31'b0, adesM},      {31'b0, vecs[i].eAdes});
      check({vecs[i].name, "_bad"},   bad_addrM,           vecs[i].eBad);
      check({vecs[i].name, "_stall"}, {31'b0, mem_stallM}, {31'b0, vecs[i].eStall});
      if (vecs[i].eReq) begin
        check({vecs[i].name, "_addr"}, data_addr, vecs[i].addr);
        check({vecs[i].name, "_size"}, {30'b0, data_size}, {30'b0, vecs[i].eSize});
        check({vecs[i].name, "_wr"},   {31'b0, data_wr},   {31'b0, vecs[i].eWr});
        if (vecs[i].eWr) check({vecs[i].name, "_wdata"}, data_wdata, vecs[i].eWdata);
      end
      idleInputs();
    end
    step();

    // Load latency and alignment/extension.
    doLoad("lw",      tLW,  32'h8000_1004, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
    doLoad("lb3",     tLB,  32'h8000_0003, 32'h80FF_0000, 32'hFFFF_FF80);
    doLoad("lbu3",    tLBU, 32'h8000_0003, 32'h80FF_0000, 32'h0000_0080);
    doLoad("lhu2",    tLHU, 32'h8000_0002, 32'h80FF_0000, 32'h0000_80FF);
    doLoad("lh2",     tLH,  32'h8000_0002, 32'h80FF_0000, 32'hFFFF_80FF);
    doLoad("lb2",     tLB,  32'h8000_0002, 32'h80FF_0000, 32'hFFFF_FFFF);
    doLoad("lbu0",    tLBU, 32'h8000_0000, 32'h80FF_0012, 32'h0000_0012);

    // Store completes: no load result, no stall in the data_ok cycle.
    mem_write_enM = 1'b1; l_s_typeM = tSH; alu_outM = 32'h1000_0002;
    rt_valueM = 32'h1234_ABCD; data_addr_ok = 1'b1;
    #1;
    check("sh_seq_wdata", data_wdata, 32'hABCD_ABCD);
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h5555_5555;
    #1;
    check("sh_seq_rdata", mem_rdataM, 32'h0);
    check("sh_seq_stall", {31'b0, mem_stallM}, 32'd0);
    step();
    idleInputs();

    // addr_ok low three cycles: request and address held four cycles.
    mem_read_enM = 1'b1; l_s_typeM = tLW; alu_outM = 32'h0000_0A40;
    for (int c = 0; c < 4; c++) begin
      data_addr_ok = (c == 3);
      #1;
      check($sformatf("hold_req%0d", c),   {31'b0, data_req},   32'd1);
      check($sformatf("hold_addr%0d", c),  data_addr,           32'h0000_0A40);
      check($sformatf("hold_stall%0d", c), {31'b0, mem_stallM}, 32'd1);
      step();
      alu_outM = 32'hBAD0_0000;
    end
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0BAD_F00D;
    #1;
    check("hold_data", mem_rdataM, 32'h0BAD_F00D);
    step();
    idleInputs();

    // Flush during WAIT, then a new LW waits for the old data_ok.
    mem_read_enM = 1'b1; l_s_typeM = tLW; alu_outM = 32'h0000_1000; data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0; flushM = 1'b1;
    #1;
    check("fl_stall0", {31'b0, mem_stallM}, 32'd0);
    check("fl_req0",   {31'b0, data_req},   32'd0);
    step();
    flushM = 1'b0; alu_outM = 32'h0000_2000;
    #1;
    check("fl_req1",   {31'b0, data_req},   32'd0);
    check("fl_stall1", {31'b0, mem_stallM}, 32'd1);
    step();
    data_data_ok = 1'b1; data_rdata = 32'h1111_1111;
    #1;
    check("fl_old_req",   {31'b0, data_req},   32'd0);
    check("fl_old_stall", {31'b0, mem_stallM}, 32'd1);
    check("fl_old_data",  mem_rdataM,          32'h0);
    step();
    data_data_ok = 1'b0; data_addr_ok = 1'b1;
    #1;
    check("fl_new_req",  {31'b0, data_req}, 32'd1);
    check("fl_new_addr", data_addr,         32'h0000_2000);
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h2222_2222;
    #1;
    check("fl_new_data",  mem_rdataM,          32'h2222_2222);
    check("fl_new_stall", {31'b0, mem_stallM}, 32'd0);
    step();
    idleInputs();

    // data_ok under external stall: HOLD keeps the value, no second request.
    mem_read_enM = 1'b1; l_s_typeM = tLW; alu_outM = 32'h0000_3000; data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D; stall_extM = 1'b1;
    #1;
    check("hd_data0", mem_rdataM, 32'hCAFE_F00D);
    step();
    data_data_ok = 1'b0; data_rdata = 32'h0;
    for (int c = 1; c < 3; c++) begin
      stall_extM = (c == 1);
      #1;
      check($sformatf("hd_data%0d", c),  mem_rdataM,          32'hCAFE_F00D);
      check($sformatf("hd_req%0d", c),   {31'b0, data_req},   32'd0);
      check($sformatf("hd_stall%0d", c), {31'b0, mem_stallM}, 32'd0);
      step();
    end
    idleInputs();

    // Flush in HOLD beats the external stall; the next load issues at once.
    mem_read_enM = 1'b1; l_s_typeM = tLW; alu_outM = 32'h0000_4000; data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h0; stall_extM = 1'b1;
    step();
    data_data_ok = 1'b0; flushM = 1'b1;
    step();
    flushM = 1'b0; stall_extM = 1'b0; alu_outM = 32'h0000_5000;
    #1;
    check("hf_req", {31'b0, data_req}, 32'd1);
    idleInputs();
    step();

    // Reset asserted mid-WAIT.
    mem_read_enM = 1'b1; l_s_typeM = tLW; alu_outM = 32'h0000_6000; data_addr_ok = 1'b1;
    step();
    data_addr_ok = 1'b0; rst = 1'b0; data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF;
    #1;
    check("rw_req",   {31'b0, data_req},   32'd0);
    check("rw_stall", {31'b0, mem_stallM}, 32'd0);
    check("rw_rdata", mem_rdataM,          32'h0);
    step();
    rst = 1'b1; data_data_ok = 1'b0; mem_read_enM = 1'b0;
    #1;
    check("rw_rel_req", {31'b0, data_req}, 32'd0);
    mem_read_enM = 1'b1;
    #1;
    check("rw_idle_req",   {31'b0, data_req}, 32'd1);
    check("rw_idle_stall", {31'b0, mem_stallM}, 32'd1);
    idleInputs();
    step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of test expected finish");
    $fatal(1);
  end

endmodule
